// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master: FSM state encoding, mode-bit positions, mosi idle level.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LEAD,
        TRAIL,
        FINISH
    } spi_state_e;

    localparam int   CPOL_BIT  = 1;
    localparam int   CPHA_BIT  = 0;
    localparam logic MOSI_IDLE = 1'b1;

endpackage

// File: rtl/spi_clkdiv.sv
// Half-period tick generator: reloadable down-counter, one-cycle tick every div+1 enabled cycles.
module spi_clkdiv #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;

    // The divider is captured on load so a running transfer ignores later div_i changes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            div_q <= div_i;
            cnt_q <= div_i;
        end else if (en_i) begin
            if (cnt_q == '0) begin
                cnt_q <= div_q;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/spi_master.sv
// Parametrised SPI master with start/busy/done handshake, CPOL/CPHA modes, runtime divider and CS hold.
// Optional feature macro: SPI_MASTER_LSB_FIRST_EN adds lsb_first_i for LSB-first transfers.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CS_N   = 1,
    parameter int DIV_W  = 8
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic                                       start_i,
    input  logic [((CS_N > 1) ? $clog2(CS_N) : 1)-1:0] cs_sel_i,
    input  logic                                       hold_i,
    input  logic [1:0]                                 mode_i,
    input  logic [DIV_W-1:0]                           div_i,
    input  logic [DATA_W-1:0]                          tx_i,
`ifdef SPI_MASTER_LSB_FIRST_EN
    input  logic                                       lsb_first_i,
`endif
    output logic [DATA_W-1:0]                          rx_o,
    output logic                                       busy_o,
    output logic                                       done_o,
    output logic                                       sclk_o,
    output logic                                       mosi_o,
    input  logic                                       miso_i,
    output logic [CS_N-1:0]                            cs_o
);

    localparam int CNT_W = $clog2(DATA_W);

    spi_state_e        state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic              hold_q, hold_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [CNT_W-1:0]  bit_q, bit_d;
    logic [CS_N-1:0]   cs_q, cs_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              done_q, done_d;
    logic              accept, tick, cpha;
    logic              lsb_acc, lsb_cur;

`ifdef SPI_MASTER_LSB_FIRST_EN
    logic lsb_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lsb_q <= 1'b0;
        end else if (accept) begin
            lsb_q <= lsb_first_i;
        end
    end
    assign lsb_acc = lsb_first_i;
    assign lsb_cur = lsb_q;
`else
    // Tied low so the direction selects below fold into plain MSB-first shifts.
    assign lsb_acc = 1'b0;
    assign lsb_cur = 1'b0;
`endif

    function automatic logic head(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] drop(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    function automatic logic [DATA_W-1:0] push(input logic [DATA_W-1:0] w, input logic b,
                                               input logic lsb);
        return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
    endfunction

    assign accept = start_i && (state_q == IDLE);
    assign cpha   = mode_q[CPHA_BIT];
    assign busy_o = (state_q != IDLE);

    spi_clkdiv #(.DIV_W(DIV_W)) u_clkdiv (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (accept),
        .en_i   (busy_o),
        .div_i  (div_i),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        hold_d  = hold_q;
        tx_sh_d = tx_sh_q;
        rx_sh_d = rx_sh_q;
        rx_d    = rx_q;
        bit_d   = bit_q;
        cs_d    = cs_q;
        mosi_d  = mosi_q;
        done_d  = 1'b0;
        if (accept) begin
            state_d = SETUP;
            mode_d  = mode_i;
            hold_d  = hold_i;
            bit_d   = CNT_W'(DATA_W - 1);
            rx_sh_d = '0;
            // Selecting a new line also releases any CS still held from a burst.
            cs_d    = ~(CS_N'(1) << cs_sel_i);
            if (mode_i[CPHA_BIT]) begin
                tx_sh_d = tx_i;
                mosi_d  = MOSI_IDLE;
            end else begin
                mosi_d  = head(tx_i, lsb_acc);
                tx_sh_d = drop(tx_i, lsb_acc);
            end
        end else if (tick) begin
            case (state_q)
                SETUP:   state_d = LEAD;
                LEAD:    state_d = TRAIL;
                TRAIL: begin
                    if (bit_q == '0) begin
                        state_d = FINISH;
                    end else begin
                        state_d = LEAD;
                        bit_d   = bit_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (state_d == LEAD) begin
                if (cpha) begin
                    mosi_d  = head(tx_sh_q, lsb_cur);
                    tx_sh_d = drop(tx_sh_q, lsb_cur);
                end else begin
                    rx_sh_d = push(rx_sh_q, miso_i, lsb_cur);
                end
            end
            if (state_d == TRAIL) begin
                if (cpha) begin
                    rx_sh_d = push(rx_sh_q, miso_i, lsb_cur);
                end else if (bit_q != '0) begin
                    mosi_d  = head(tx_sh_q, lsb_cur);
                    tx_sh_d = drop(tx_sh_q, lsb_cur);
                end
            end
            if (state_d == IDLE) begin
                rx_d   = rx_sh_q;
                done_d = 1'b1;
                mosi_d = MOSI_IDLE;
                if (!hold_q) begin
                    cs_d = '1;
                end
            end
        end
        sclk_d = mode_d[CPOL_BIT] ^ (state_d == LEAD);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            mode_q  <= 2'b00;
            hold_q  <= 1'b0;
            tx_sh_q <= '0;
            rx_sh_q <= '0;
            rx_q    <= '0;
            bit_q   <= '0;
            cs_q    <= '1;
            sclk_q  <= 1'b0;
            mosi_q  <= MOSI_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            hold_q  <= hold_d;
            tx_sh_q <= tx_sh_d;
            rx_sh_q <= rx_sh_d;
            rx_q    <= rx_d;
            bit_q   <= bit_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
        end
    end

    assign rx_o   = rx_q;
    assign done_o = done_q;
    assign sclk_o = sclk_q;
    assign mosi_o = mosi_q;
    assign cs_o   = cs_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: scoreboard of expected rx words, SPI slave model, CS/busy/timing checks.
module tb_spi_master;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        start    = 1'b0;
    logic        start16  = 1'b0;
    logic        hold     = 1'b0;
    logic        loopback = 1'b1;
    logic [1:0]  cs_sel   = 2'd0;
    logic [1:0]  mode     = 2'd0;
    logic [7:0]  div      = 8'd0;
    logic [7:0]  tx       = 8'd0;
    logic [15:0] tx16     = 16'd0;

    logic [7:0]  rx;
    logic        busy, done, sclk, mosi, miso;
    logic [3:0]  cs;
    logic [15:0] rx16;
    logic        busy16, done16, sclk16, mosi16;
    logic [0:0]  cs16;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q[$];

    // SPI slave model state (answers 8'h3C, records what it received).
    logic [1:0]  s_mode    = 2'd0;
    logic        slv_miso  = 1'b0;
    logic [7:0]  slv_sh    = 8'h00;
    logic [7:0]  slv_rx    = 8'h00;
    logic        slv_lead  = 1'b0;
    logic        cs_prev   = 1'b1;
    logic        sclk_prev = 1'b0;

    always #5 clk = ~clk;

    assign miso = loopback ? mosi : slv_miso;

    spi_master #(.DATA_W(8), .CS_N(4), .DIV_W(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .cs_sel_i    (cs_sel),
        .hold_i      (hold),
        .mode_i      (mode),
        .div_i       (div),
        .tx_i        (tx),
`ifdef SPI_MASTER_LSB_FIRST_EN
        .lsb_first_i (1'b0),
`endif
        .rx_o        (rx),
        .busy_o      (busy),
        .done_o      (done),
        .sclk_o      (sclk),
        .mosi_o      (mosi),
        .miso_i      (miso),
        .cs_o        (cs)
    );

    spi_master #(.DATA_W(16), .CS_N(1), .DIV_W(8)) dut16 (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start16),
        .cs_sel_i    (1'b0),
        .hold_i      (1'b0),
        .mode_i      (mode),
        .div_i       (div),
        .tx_i        (tx16),
`ifdef SPI_MASTER_LSB_FIRST_EN
        .lsb_first_i (1'b0),
`endif
        .rx_o        (rx16),
        .busy_o      (busy16),
        .done_o      (done16),
        .sclk_o      (sclk16),
        .mosi_o      (mosi16),
        .miso_i      (mosi16),
        .cs_o        (cs16)
    );

    always @(cs or sclk) begin
        if (cs[0] !== cs_prev) begin
            slv_lead = 1'b0;
            if (cs[0] == 1'b0) begin
                slv_sh = 8'h3C;
                slv_rx = 8'h00;
                if (!s_mode[0]) slv_miso = slv_sh[7];
            end
        end
        if (sclk !== sclk_prev && cs[0] == 1'b0) begin
            if (sclk != s_mode[1]) begin
                slv_lead = 1'b1;
                if (s_mode[0]) begin
                    slv_miso = slv_sh[7];
                    slv_sh   = slv_sh << 1;
                end else begin
                    slv_rx = {slv_rx[6:0], mosi};
                end
            end else if (slv_lead) begin
                if (s_mode[0]) begin
                    slv_rx = {slv_rx[6:0], mosi};
                end else begin
                    slv_sh   = slv_sh << 1;
                    slv_miso = slv_sh[7];
                end
            end
        end
        cs_prev   = cs[0];
        sclk_prev = sclk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_xfer(input logic [1:0] sel, input logic hld, input logic [1:0] md,
                              input logic [7:0] dv, input logic [7:0] data,
                              input logic [7:0] expect_rx);
        cs_sel = sel;
        hold   = hld;
        mode   = md;
        div    = dv;
        tx     = data;
        start  = 1'b1;
        exp_q.push_back(expect_rx);
        $display("xfer sel=%0d hold=%0d mode=%0d div=%0d tx=%02h exp_rx=%02h",
                 sel, hld, md, dv, data, expect_rx);
    endtask

    // Waits for done; counts busy cycles and CS mismatches; pops the scoreboard on done.
    task automatic wait_done(input string tag, input int budget, input logic [3:0] exp_cs,
                             input int pulse_at, output int busy_cycles, output int iters);
        logic       got;
        int         cs_bad;
        logic [7:0] e;
        got = 1'b0;
        cs_bad = 0;
        busy_cycles = 0;
        iters = 0;
        while (!got && iters < budget) begin
            @(negedge clk);
            iters++;
            start = (iters == pulse_at);
            if (iters == pulse_at) begin
                tx     = 8'hFF;
                cs_sel = 2'd3;
            end
            if (busy) begin
                busy_cycles++;
                if (cs !== exp_cs) cs_bad++;
            end
            if (done) got = 1'b1;
        end
        check({tag, "_done"}, 32'(got), 32'd1);
        check({tag, "_cs"}, 32'(cs_bad), 32'd0);
        if (got && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_rx"}, 32'(rx), 32'(e));
        end
    endtask

    initial begin
        int   bc, it, t1, t2, cs16_bad;
        logic got, prev, seen;

        repeat (3) @(negedge clk);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd1);
        check("rst_cs", 32'(cs), 32'hF);
        check("rst_rx", 32'(rx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Mode 0 loopback, fastest divider.
        start_xfer(2'd0, 1'b0, 2'd0, 8'd0, 8'hA5, 8'hA5);
        wait_done("t1", 40, 4'b1110, 0, bc, it);
        check("t1_busy", 32'(bc), 32'd18);
        check("t1_cs_after", 32'(cs), 32'hF);
        @(negedge clk);
        check("t1_done_pulse", 32'(done), 32'd0);

        // All four modes against the slave model.
        loopback = 1'b0;
        for (int m = 0; m < 4; m++) begin
            s_mode = 2'(m);
            start_xfer(2'd0, 1'b0, 2'(m), 8'd3, 8'hC3, 8'h3C);
            wait_done($sformatf("mode%0d", m), 200, 4'b1110, 0, bc, it);
            check($sformatf("mode%0d_busy", m), 32'(bc), 32'd72);
            check($sformatf("mode%0d_slave", m), 32'(slv_rx), 32'hC3);
            check($sformatf("mode%0d_sclk_idle", m), 32'(sclk), 32'(m[1]));
            @(negedge clk);
        end
        loopback = 1'b1;

        // Burst of three words, each started in the previous done cycle.
        start_xfer(2'd0, 1'b1, 2'd0, 8'd0, 8'h11, 8'h11);
        wait_done("burst0", 40, 4'b1110, 0, bc, it);
        check("burst0_len", 32'(it), 32'd19);
        check("burst0_hold", 32'(cs), 32'hE);
        start_xfer(2'd0, 1'b1, 2'd0, 8'd0, 8'h22, 8'h22);
        wait_done("burst1", 40, 4'b1110, 0, bc, it);
        check("burst1_len", 32'(it), 32'd19);
        check("burst1_hold", 32'(cs), 32'hE);
        start_xfer(2'd0, 1'b0, 2'd0, 8'd0, 8'h33, 8'h33);
        wait_done("burst2", 40, 4'b1110, 0, bc, it);
        check("burst2_len", 32'(it), 32'd19);
        check("burst2_release", 32'(cs), 32'hF);
        @(negedge clk);

        // Chip-select switching from a held line.
        start_xfer(2'd2, 1'b1, 2'd0, 8'd0, 8'h5A, 8'h5A);
        wait_done("csw0", 40, 4'b1011, 0, bc, it);
        check("csw0_held", 32'(cs), 32'hB);
        start_xfer(2'd1, 1'b0, 2'd0, 8'd0, 8'h96, 8'h96);
        wait_done("csw1", 40, 4'b1101, 0, bc, it);
        check("csw1_release", 32'(cs), 32'hF);
        @(negedge clk);

        // Start pulsed mid-transfer with different tx/cs_sel must be ignored.
        start_xfer(2'd0, 1'b0, 2'd0, 8'd3, 8'h5A, 8'h5A);
        wait_done("ign", 200, 4'b1110, 10, bc, it);
        check("ign_busy", 32'(bc), 32'd72);
        repeat (3) @(negedge clk);
        check("ign_idle", 32'(busy), 32'd0);

        // Reset in the middle of a slow transfer (first LEAD, sclk high, mosi low).
        start_xfer(2'd0, 1'b0, 2'd0, 8'd255, 8'h5A, 8'h5A);
        @(negedge clk);
        start = 1'b0;
        repeat (300) @(negedge clk);
        check("abort_sclk_before", 32'(sclk), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_cs", 32'(cs), 32'hF);
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_mosi", 32'(mosi), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rx", 32'(rx), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        seen = 1'b0;
        repeat (600) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("abort_no_done", 32'(seen), 32'd0);

        // Slowest divider on the 16-bit instance.
        mode    = 2'd0;
        div     = 8'd255;
        tx16    = 16'hBEEF;
        start16 = 1'b1;
        $display("xfer16 div=255 tx=%04h exp_rx=%04h", tx16, 16'hBEEF);
        bc = 0; it = 0; t1 = -1; t2 = -1; cs16_bad = 0;
        got = 1'b0;
        prev = sclk16;
        while (!got && it < 9000) begin
            @(negedge clk);
            it++;
            start16 = 1'b0;
            if (busy16) begin
                bc++;
                if (cs16 !== 1'b0) cs16_bad++;
            end
            if (sclk16 !== prev) begin
                if (t1 < 0) t1 = it;
                else if (t2 < 0) t2 = it;
            end
            prev = sclk16;
            if (done16) got = 1'b1;
        end
        check("slow_done", 32'(got), 32'd1);
        check("slow_busy", 32'(bc), 32'd8704);
        check("slow_half", 32'(t2 - t1), 32'd256);
        check("slow_cs", 32'(cs16_bad), 32'd0);
        check("slow_rx", 32'(rx16), 32'hBEEF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
